// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state type and bit-slot geometry for the I2C master.
// No ports. Optional feature elsewhere: I2C_MASTER_ACK_CHECK_EN.
package i2c_pkg;
  localparam int ADDR_W      = 7;
  localparam int QUARTERS    = 4;
  localparam int BYTE_SLOTS  = 8;
  localparam int TOTAL_SLOTS = 20;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_NACK, STOP
  } state_t;
endpackage

// File: rtl/i2c_master_if.sv
// i2c_master_if: request/response handshake plus push-pull SCL of the I2C master.
// Signals: start, rw, addr, wdata (requester -> master); rdata, busy, done, ack_err, scl (master -> requester/bus).
// Modports: master (the controller), slave (the requester side).
interface i2c_master_if;
  import i2c_pkg::*;
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              busy;
  logic              done;
  logic              ack_err;
  logic              scl;
  modport master (input start, rw, addr, wdata, output rdata, busy, done, ack_err, scl);
  modport slave (output start, rw, addr, wdata, input rdata, busy, done, ack_err, scl);
endinterface

// File: rtl/i2c_clk_div.sv
// i2c_clk_div: emits a one-cycle quarter tick every CLK_DIV clk cycles while enabled.
// Ports: clk, rst (async active-low), en (count enable), tick (quarter-period strobe).
module i2c_clk_div #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= (!en || r_cnt == W'(CLK_DIV - 1)) ? '0 : r_cnt + 1'b1;
  assign tick = en && r_cnt == W'(CLK_DIV - 1);
endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (START, address+rw, one data byte, STOP).
// Ports: clk, rst (async active-low), bus (i2c_master_if.master: start/rw/addr/wdata in,
//        rdata/busy/done/ack_err/scl out), sda (open-drain inout, only ever pulled low).
// Option: define I2C_MASTER_ACK_CHECK_EN to report NACKs on ack_err and cut the
//         transfer short to STOP after an address NACK.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic               clk,
  input  logic               rst,
  i2c_master_if.master       bus,
  inout  wire                sda
);
  state_t      r_state, w_next;
  logic [1:0]  r_q;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift, r_wbyte, r_rdata;
  logic        r_rw, r_done;
  logic        w_busy, w_tick, w_sample, w_last_q, w_accept, w_abort;
  logic        w_scl, w_sda_low, w_sda_in;

  assign w_busy   = r_state != IDLE;
  assign w_sample = w_tick && r_q == 2'd2;
  assign w_last_q = w_tick && r_q == 2'd3;
  // a start arriving while the done pulse is up is deliberately dropped
  assign w_accept = bus.start && !w_busy && !r_done;
  assign w_sda_in = sda;

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst(rst), .en(w_busy), .tick(w_tick));

`ifdef I2C_MASTER_ACK_CHECK_EN
  logic r_ack_err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ack_err <= 1'b0;
    else if (w_accept) r_ack_err <= 1'b0;
    else if (w_sample && (r_state == ADDR_ACK || r_state == WR_ACK) && w_sda_in) r_ack_err <= 1'b1;
  // the flag is already set by q3 of ADDR_ACK, in time to steer the slot-end transition
  assign w_abort     = r_ack_err;
  assign bus.ack_err = r_ack_err;
`else
  assign w_abort     = 1'b0;
  assign bus.ack_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = START;
    else if (w_last_q)
      case (r_state)
        START:    w_next = ADDR;
        ADDR:     w_next = r_bit == 3'd7 ? ADDR_ACK : ADDR;
        ADDR_ACK: w_next = w_abort ? STOP : r_rw ? RD : WR;
        WR:       w_next = r_bit == 3'd7 ? WR_ACK : WR;
        WR_ACK:   w_next = STOP;
        RD:       w_next = r_bit == 3'd7 ? RD_NACK : RD;
        RD_NACK:  w_next = STOP;
        STOP:     w_next = IDLE;
        default:  w_next = IDLE;
      endcase
  end

  // SCL/SDA are pure decodes of state and quarter so reset releases the bus in the same cycle
  always_comb begin
    w_scl     = (r_state == IDLE || r_state == START) ? 1'b1 : r_state == STOP ? r_q != 2'd0 : r_q[1];
    w_sda_low = r_state == START ? r_q[1] :
                r_state == STOP ? !r_q[1] :
                (r_state == ADDR || r_state == WR) ? !r_shift[7] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_wbyte <= '0;
      r_rdata <= '0;
      r_rw    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == STOP && w_last_q;
      if (w_accept) begin
        r_q     <= '0;
        r_bit   <= '0;
        r_shift <= {bus.addr, bus.rw};
        r_wbyte <= bus.wdata;
        r_rw    <= bus.rw;
      end else if (w_tick) begin
        r_q <= r_q + 2'd1;
        if (w_sample && r_state == RD) r_shift <= {r_shift[6:0], w_sda_in};
        if (w_last_q) begin
          if (r_state == ADDR || r_state == WR) r_shift <= {r_shift[6:0], 1'b0};
          if (r_state == ADDR_ACK) r_shift <= r_wbyte;
          if (r_state == ADDR || r_state == WR || r_state == RD) r_bit <= r_bit + 3'd1;
          if (r_state == RD_NACK) r_rdata <= r_shift;
        end
      end
    end

  assign sda       = w_sda_low ? 1'b0 : 1'bz;
  assign bus.scl   = w_scl;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a bus monitor and a byte-level target model at 0x50.
module tb_i2c_master;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  sda;
  logic tgt_low = 1'b0;
  logic [7:0] tgt_rdata = 8'h3C;
  int vectors = 0;
  int miscompares = 0;

  i2c_master_if bus ();
  i2c_master #(.CLK_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus), .sda(sda));

  pullup (sda);
  assign sda = tgt_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  // bus monitor + target: decodes START/STOP, counts SCL rises, logs bytes and ack bits
  int n_start = 0, n_stop = 0, n_done = 0, rises = 0, nb;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] sh = '0, abyte = '0;
  logic [7:0] byte_log[$];
  logic ack_log[$];
  always @(negedge clk) begin
    if (prev_scl && bus.scl && prev_sda && !sda) begin
      n_start++; rises = 0; tgt_low = 1'b0;
    end else if (prev_scl && bus.scl && !prev_sda && sda) n_stop++;
    else if (!prev_scl && bus.scl) begin
      rises++;
      sh = {sh[6:0], sda};
      if (rises == 8) begin abyte = sh; byte_log.push_back(sh); end
      if (rises == 17) byte_log.push_back(sh);
      if (rises == 9 || rises == 18) ack_log.push_back(sda);
    end else if (prev_scl && !bus.scl) begin
      nb = rises + 1;
      tgt_low = 1'b0;
      if (abyte[7:1] == 7'h50) begin
        if (nb == 9) tgt_low = 1'b1;
        if (abyte[0] && nb >= 10 && nb <= 17) tgt_low = !tgt_rdata[17 - nb];
        if (!abyte[0] && nb == 18) tgt_low = 1'b1;
      end
    end
    if (bus.done === 1'b1) n_done++;
    prev_scl = bus.scl;
    prev_sda = sda;
  end

  task automatic do_txn(input logic r, input logic [6:0] a, input logic [7:0] d, output int cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 400 && cyc < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) cyc = c;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; #2 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    vectors++; if (bus.scl !== 1'b1) begin miscompares++; $display("FAIL reset_scl got=%b exp=1", bus.scl); end
    vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL reset_sda got=%b exp=1(released)", sda); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vectors++; if (bus.ack_err !== 1'b0) begin miscompares++; $display("FAIL reset_ack_err got=%b exp=0", bus.ack_err); end
    vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_write;
    int cyc, nbl, nal, s, p, dn;
    nbl = byte_log.size(); nal = ack_log.size(); s = n_start; p = n_stop; dn = n_done;
    do_txn(1'b0, 7'h50, 8'hA5, cyc);
    vectors++; if (cyc !== 320) begin miscompares++; $display("FAIL wr_done_cycle got=%0d exp=320", cyc); end
    vectors++; if (bus.ack_err !== 1'b0) begin miscompares++; $display("FAIL wr_ack_err got=%b exp=0", bus.ack_err); end
    vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("FAIL wr_rdata_kept got=%h exp=00", bus.rdata); end
    @(posedge clk); #1;
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL wr_done_width got=%b exp=0", bus.done); end
    repeat (2) @(negedge clk);
    vectors++; if (byte_log.size() - nbl !== 2) begin miscompares++; $display("FAIL wr_byte_count got=%0d exp=2", byte_log.size() - nbl); end
    else begin
      vectors++; if (byte_log[nbl] !== 8'hA0) begin miscompares++; $display("FAIL wr_addr_byte got=%h exp=a0", byte_log[nbl]); end
      vectors++; if (byte_log[nbl+1] !== 8'hA5) begin miscompares++; $display("FAIL wr_data_byte got=%h exp=a5", byte_log[nbl+1]); end
    end
    vectors++; if (ack_log.size() - nal !== 2) begin miscompares++; $display("FAIL wr_ack_count got=%0d exp=2", ack_log.size() - nal); end
    vectors++; if (n_start - s !== 1) begin miscompares++; $display("FAIL wr_start_edges got=%0d exp=1", n_start - s); end
    vectors++; if (n_stop - p !== 1) begin miscompares++; $display("FAIL wr_stop_edges got=%0d exp=1", n_stop - p); end
    vectors++; if (n_done - dn !== 1) begin miscompares++; $display("FAIL wr_done_pulses got=%0d exp=1", n_done - dn); end
  endtask

  task automatic test_read;
    int cyc, nbl, nal, p;
    nbl = byte_log.size(); nal = ack_log.size(); p = n_stop;
    do_txn(1'b1, 7'h50, 8'h00, cyc);
    vectors++; if (cyc !== 320) begin miscompares++; $display("FAIL rd_done_cycle got=%0d exp=320", cyc); end
    vectors++; if (bus.rdata !== 8'h3C) begin miscompares++; $display("FAIL rd_rdata got=%h exp=3c", bus.rdata); end
    repeat (2) @(negedge clk);
    vectors++; if (byte_log.size() - nbl !== 2 || ack_log.size() - nal !== 2) begin
      miscompares++; $display("FAIL rd_log_count got=%0d/%0d exp=2/2", byte_log.size() - nbl, ack_log.size() - nal);
    end else begin
      vectors++; if (byte_log[nbl] !== 8'hA1) begin miscompares++; $display("FAIL rd_addr_byte got=%h exp=a1", byte_log[nbl]); end
      vectors++; if (byte_log[nbl+1] !== 8'h3C) begin miscompares++; $display("FAIL rd_bus_byte got=%h exp=3c", byte_log[nbl+1]); end
      vectors++; if (ack_log[nal] !== 1'b0) begin miscompares++; $display("FAIL rd_target_ack got=%b exp=0", ack_log[nal]); end
      vectors++; if (ack_log[nal+1] !== 1'b1) begin miscompares++; $display("FAIL rd_master_nack got=%b exp=1", ack_log[nal+1]); end
    end
    vectors++; if (n_stop - p !== 1) begin miscompares++; $display("FAIL rd_stop_edges got=%0d exp=1", n_stop - p); end
  endtask

  task automatic test_addr_nack;
    int cyc, nbl, exp_cyc, exp_bytes;
    logic exp_err;
`ifdef I2C_MASTER_ACK_CHECK_EN
    exp_cyc = 44 * DIV; exp_err = 1'b1; exp_bytes = 1;
`else
    exp_cyc = 80 * DIV; exp_err = 1'b0; exp_bytes = 2;
`endif
    nbl = byte_log.size();
    do_txn(1'b0, 7'h22, 8'h11, cyc);
    vectors++; if (cyc !== exp_cyc) begin miscompares++; $display("FAIL nack_done_cycle got=%0d exp=%0d", cyc, exp_cyc); end
    vectors++; if (bus.ack_err !== exp_err) begin miscompares++; $display("FAIL nack_ack_err got=%b exp=%b", bus.ack_err, exp_err); end
    vectors++; if (bus.rdata !== 8'h3C) begin miscompares++; $display("FAIL nack_rdata_kept got=%h exp=3c", bus.rdata); end
    repeat (2) @(negedge clk);
    vectors++; if (byte_log.size() - nbl !== exp_bytes) begin miscompares++; $display("FAIL nack_byte_count got=%0d exp=%0d", byte_log.size() - nbl, exp_bytes); end
    else begin
      vectors++; if (byte_log[nbl] !== 8'h44) begin miscompares++; $display("FAIL nack_addr_byte got=%h exp=44", byte_log[nbl]); end
    end
`ifdef I2C_MASTER_ACK_CHECK_EN
    do_txn(1'b1, 7'h22, 8'h00, cyc);
    vectors++; if (cyc !== exp_cyc) begin miscompares++; $display("FAIL nack_rd_done_cycle got=%0d exp=%0d", cyc, exp_cyc); end
    vectors++; if (bus.rdata !== 8'h3C) begin miscompares++; $display("FAIL nack_rd_rdata_kept got=%h exp=3c", bus.rdata); end
`endif
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int nbl, dn, done_at;
    nbl = byte_log.size(); dn = n_done; done_at = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h50; bus.wdata = 8'h5A;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (c == 50) begin bus.rw = 1'b1; bus.addr = 7'h22; bus.wdata = 8'hFF; end
      if (bus.done === 1'b1 && done_at < 0) done_at = c;
      bus.start = (c == 50) || (c == done_at);
      if (c == done_at + 1 && done_at > 0) begin
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done_cycle_start got_busy=%b exp=0", bus.busy); end
      end
    end
    bus.start = 1'b0;
    vectors++; if (done_at !== 320) begin miscompares++; $display("FAIL b2b_done_cycle got=%0d exp=320", done_at); end
    vectors++; if (n_done - dn !== 1) begin miscompares++; $display("FAIL b2b_done_pulses got=%0d exp=1", n_done - dn); end
    vectors++; if (byte_log.size() - nbl !== 2) begin miscompares++; $display("FAIL b2b_byte_count got=%0d exp=2", byte_log.size() - nbl); end
    else begin
      vectors++; if (byte_log[nbl] !== 8'hA0) begin miscompares++; $display("FAIL b2b_addr_byte got=%h exp=a0", byte_log[nbl]); end
      vectors++; if (byte_log[nbl+1] !== 8'h5A) begin miscompares++; $display("FAIL b2b_data_byte got=%h exp=5a", byte_log[nbl+1]); end
    end
  endtask

  task automatic test_reset_mid;
    int cyc, dn, nbl;
    dn = n_done;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h50; bus.wdata = 8'hA5;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (81) @(posedge clk);
    #1;
    vectors++; if (bus.scl !== 1'b0 || sda !== 1'b0) begin miscompares++; $display("FAIL mid_pre_bus got=scl%b/sda%b exp=scl0/sda0", bus.scl, sda); end
    rst = 1'b0; #1;
    vectors++; if (bus.scl !== 1'b1) begin miscompares++; $display("FAIL mid_scl got=%b exp=1", bus.scl); end
    vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL mid_sda got=%b exp=1(released)", sda); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("FAIL mid_rdata got=%h exp=00", bus.rdata); end
    repeat (3) @(posedge clk); #1 rst = 1'b1;
    repeat (400) @(posedge clk); #1;
    vectors++; if (n_done - dn !== 0) begin miscompares++; $display("FAIL mid_no_done got=%0d exp=0", n_done - dn); end
    nbl = byte_log.size();
    do_txn(1'b0, 7'h50, 8'h3C, cyc);
    vectors++; if (cyc !== 320) begin miscompares++; $display("FAIL mid_retry_cycle got=%0d exp=320", cyc); end
    repeat (2) @(negedge clk);
    vectors++; if (byte_log.size() - nbl !== 2) begin miscompares++; $display("FAIL mid_retry_bytes got=%0d exp=2", byte_log.size() - nbl); end
    else begin
      vectors++; if (byte_log[nbl+1] !== 8'h3C) begin miscompares++; $display("FAIL mid_retry_data got=%h exp=3c", byte_log[nbl+1]); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250: clk cycles per SCL quarter-period (min 2).
REQ-002 SHALL have port clk, input, 1, single system clock; all flops on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, one-cycle transaction request.
REQ-005 SHALL have port rw, input, 1, 0 = write byte, 1 = read byte; sampled with start.
REQ-006 SHALL have port addr, input, 7, target address; sampled with start.
REQ-007 SHALL have port wdata, input, 8, write byte; sampled with start.
REQ-008 SHALL have port rdata, output, 8, byte read from the target.
REQ-009 SHALL have port busy, output, 1, high from start accept to done.
REQ-010 SHALL have port done, output, 1, one-cycle end-of-transaction pulse.
REQ-011 SHALL have port ack_err, output, 1, NACK seen in the last transaction; valid with done.
REQ-012 SHALL have port scl, output, 1, push-pull bus clock; no clock stretching.
REQ-013 SHALL have port sda, inout, 1, open-drain: driven 0 or high-Z, never driven 1.

Function
REQ-014 SHALL generate a quarter tick every CLK_DIV clk cycles while busy; each bit slot spans 4 quarters q0..q3.
REQ-015 SHALL, in data slots, hold SCL low q0-q1 and high q2-q3, update SDA at q0 start, and sample SDA at q3 start.
REQ-016 SHALL use FSM states IDLE, START, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_NACK, STOP.
REQ-017 SHALL, in START, hold SCL high all slot, with SDA released q0-q1 and pulled low q2-q3.
REQ-018 SHALL, in ADDR, shift {addr, rw} MSB first over 8 slots.
REQ-019 SHALL release SDA in ADDR_ACK and WR_ACK and sample the target's ACK (0 = ACK).
REQ-020 SHALL, in WR, shift wdata MSB first; in RD, release SDA and shift in MSB first.
REQ-021 SHALL, in RD_NACK, release SDA (master NACK), then load rdata from the shift register.
REQ-022 SHALL, in STOP, hold SDA low q0-q1 with SCL low q0 and high q1-q3, then release SDA at q2.
REQ-023 SHALL, on a full transaction (20 slots), assert done exactly 80*CLK_DIV cycles after the start-accept cycle, then return to IDLE.
REQ-024 SHALL ignore start while busy; start in the done cycle is also ignored.
REQ-025 SHALL leave rdata unchanged on write transactions and on aborted reads.

Reset
REQ-026 SHALL, while rst is low, immediately force IDLE: scl=1, sda released, busy=0, done=0, ack_err=0, rdata=0, counters 0.
REQ-027 SHALL, on reset mid-transaction, abandon the transfer without generating STOP and without pulsing done.

Configuration
REQ-028 SHALL, with I2C_MASTER_ACK_CHECK_EN defined, on NACK in ADDR_ACK or WR_ACK set ack_err, skip the remaining slots, go to STOP, then pulse done.
REQ-029 SHALL, without I2C_MASTER_ACK_CHECK_EN, tie ack_err to 0, ignore ACK values, and always run all 20 slots.

Structure
REQ-030 SHALL place the FSM state enum, slot/quarter count constants and ADDR_W=7 in package i2c_pkg.
REQ-031 SHALL implement the quarter-tick generator as sub-module i2c_clk_div, with CLK_DIV, enable input and tick output.

Verification
REQ-032 SHALL cover this write case: CLK_DIV=4, addr=0x50, rw=0, wdata=0xA5, ACKing target. Required: bus carries 0xA0 then 0xA5, done at cycle 320, ack_err=0.
REQ-033 SHALL cover this read case: addr=0x50, rw=1, target returns 0x3C. Required: master NACKs the data byte, rdata=0x3C with done, then STOP.
REQ-034 SHALL cover a NACK on address: addr=0x22 with no target. With the macro: ack_err=1 and done after 11 slots (44*CLK_DIV cycles). Without it: done at 320, ack_err=0.
REQ-035 SHALL cover start pulses while busy: second start is ignored, only one done pulse occurs, and the first transaction's bus bytes are unaltered.
REQ-036 SHALL cover rst low at the 5th address bit: scl=1 and sda=Z within the same cycle, no done pulse, and a new write succeeds afterwards.
REQ-037 SHALL cover bus timing: SDA never changes while SCL is high, except START and STOP edges.
